// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and matrix helpers for the matrix stack unit.
package matrix_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_LOAD_ID = 3'd4;
  localparam logic [2:0] OP_WRITE   = 3'd5;

  localparam logic [31:0] ONE_F32 = 32'h3F800000;

  // 640x480 glOrtho; column 0 sits in the MSBs of each row
  localparam logic [127:0] ORTHO_ROW0 = {32'h3B4CCCCD, 32'h0, 32'h0, 32'hBF800000};
  localparam logic [127:0] ORTHO_ROW1 = {32'h0, 32'h3B888889, 32'h0, 32'hBF800000};
  localparam logic [127:0] ORTHO_ROW2 = {32'h0, 32'h0, 32'hBF800000, 32'h0};
  localparam logic [127:0] ORTHO_ROW3 = {32'h0, 32'h0, 32'h0, 32'h3F800000};
  localparam logic [511:0] ORTHO_MAT  = {ORTHO_ROW3, ORTHO_ROW2, ORTHO_ROW1, ORTHO_ROW0};

  localparam int unsigned MAT_MAX_W = 4096;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Identity matrix in the row/column packing used on every matrix bus.
  function automatic logic [MAT_MAX_W-1:0] identity_mat(input int unsigned n,
                                                        input int unsigned ew,
                                                        input logic [63:0] one);
    logic [MAT_MAX_W-1:0] m;
    m = '0;
    for (int unsigned r = 0; r < n; r++) begin
      for (int unsigned b = 0; b < ew; b++) begin
        m[12'(r * n * ew + (n - 1 - r) * ew + b)] = one[6'(b)];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/matrix_stack_bank.sv
// One matrix stack: DEPTH slots, stack pointer, top read and over/underflow detect.
module matrix_stack_bank
  import matrix_pkg::*;
#(
  parameter int unsigned     N           = 4,
  parameter int unsigned     ELEM_W      = 32,
  parameter int unsigned     DEPTH       = 8,
  parameter logic [ELEM_W-1:0] ONE       = ELEM_W'(ONE_F32),
  parameter bit              ORTHO_SLOT0 = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           wr_en,
  input  logic [N*N*ELEM_W-1:0]          wr_data,
  output logic [N*N*ELEM_W-1:0]          top_c,
  output logic [$clog2(DEPTH)-1:0]       sp,
  output logic                           ovf_c,
  output logic                           unf_c
);

  localparam int unsigned MAT_W = N * N * ELEM_W;
  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam logic [MAT_W-1:0] ID_MAT    = MAT_W'(identity_mat(N, ELEM_W, 64'(ONE)));
  localparam logic [MAT_W-1:0] SLOT0_RST = ORTHO_SLOT0 ? MAT_W'(ORTHO_MAT) : ID_MAT;

  logic [MAT_W-1:0] mem [DEPTH];
  logic             full;
  logic             empty;

  assign full  = (sp == SP_W'(DEPTH - 1));
  assign empty = (sp == '0);
  assign top_c = mem[sp];
  assign ovf_c = push & full;
  assign unf_c = pop & empty;

  // Push duplicates the top; refused push/pop leave the stack untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp     <= '0;
      mem[0] <= SLOT0_RST;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= ID_MAT;
      end
    end else if (push) begin
      if (!full) begin
        mem[sp + SP_W'(1)] <= mem[sp];
        sp                 <= sp + SP_W'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        sp <= sp - SP_W'(1);
      end
    end else if (wr_en) begin
      mem[sp] <= wr_data;
    end
  end

endmodule

// File: rtl/matrix_stack_ctrl.sv
// Matrix stack controller: command FSM, row-wise LOAD buffer, stack select and error flags.
// Optional MATRIX_ORTHO_RESET_EN: stack 1 slot 0 resets to a 640x480 ortho projection.
module matrix_stack_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned       N          = 4,
  parameter int unsigned       ELEM_W     = 32,
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       NUM_STACKS = 2,
  parameter logic [ELEM_W-1:0] ONE        = ELEM_W'(ONE_F32),
  localparam int unsigned      MW         = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic [MW-1:0]             mode,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd_op,
  output logic                      cmd_ready,
  input  logic                      data_valid,
  input  logic [N*ELEM_W-1:0]       data_in,
  output logic                      data_ready,
  input  logic [N*N*ELEM_W-1:0]     write_in,
  output logic [N*N*ELEM_W-1:0]     peek_out,
  output logic [$clog2(DEPTH)-1:0]  depth,
  output logic                      busy,
  output logic                      err_ovf,
  output logic                      err_unf,
  input  logic                      err_clr
);

  localparam int unsigned ROW_W = N * ELEM_W;
  localparam int unsigned MAT_W = N * ROW_W;
  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);
  localparam logic [MAT_W-1:0] ID_MAT   = MAT_W'(identity_mat(N, ELEM_W, 64'(ONE)));

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             row_cnt_q, row_cnt_d;
  logic [MW-1:0]                load_mode_q;
  logic [(N-1)*ROW_W-1:0]       buf_q;
  logic                         load_start, capture;
  logic                         mode_ok, load_ok;
  logic [NUM_STACKS-1:0]        sel_oh, load_oh;
  logic [NUM_STACKS-1:0]        push_v, pop_v, wr_v, ovf_v, unf_v;
  logic [MAT_W-1:0]             wr_mat;
  logic [MAT_W-1:0]             tops [NUM_STACKS];
  logic [SP_W-1:0]              sps  [NUM_STACKS];

  assign mode_ok = (32'(mode) < 32'(NUM_STACKS));
  assign load_ok = (32'(load_mode_q) < 32'(NUM_STACKS));
  assign sel_oh  = mode_ok ? (NUM_STACKS'(1) << mode) : '0;
  assign load_oh = load_ok ? (NUM_STACKS'(1) << load_mode_q) : '0;

  assign peek_out = mode_ok ? tops[mode] : ID_MAT;
  assign depth    = mode_ok ? sps[mode] : '0;
  assign busy     = (state_q != ST_IDLE);

  for (genvar g = 0; g < NUM_STACKS; g++) begin : g_bank
`ifdef MATRIX_ORTHO_RESET_EN
    localparam bit ORTHO = (g == 1) && (N == 4) && (ELEM_W == 32);
`else
    localparam bit ORTHO = 1'b0;
`endif
    matrix_stack_bank #(
      .N(N), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .ONE(ONE), .ORTHO_SLOT0(ORTHO)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_v[g]),
      .pop     (pop_v[g]),
      .wr_en   (wr_v[g]),
      .wr_data (wr_mat),
      .top_c   (tops[g]),
      .sp      (sps[g]),
      .ovf_c   (ovf_v[g]),
      .unf_c   (unf_v[g])
    );
  end

  // Next-state, handshakes and per-stack strobes.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    push_v     = '0;
    pop_v      = '0;
    wr_v       = '0;
    wr_mat     = write_in;
    load_start = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = ~stall;
        if (cmd_valid && !stall) begin
          case (cmd_op)
            OP_PUSH:    push_v = sel_oh;
            OP_POP:     pop_v  = sel_oh;
            OP_LOAD: begin
              state_d    = ST_LOAD;
              row_cnt_d  = '0;
              load_start = 1'b1;
            end
            OP_LOAD_ID: begin
              wr_v   = sel_oh;
              wr_mat = ID_MAT;
            end
            OP_WRITE:   wr_v = sel_oh;
            default:    ;
          endcase
        end
      end
      ST_LOAD: begin
        data_ready = ~stall;
        if (data_valid && !stall) begin
          if (row_cnt_q == LAST_ROW) begin
            wr_v      = load_oh;
            wr_mat    = {data_in, buf_q};
            state_d   = ST_IDLE;
            row_cnt_d = '0;
          end else begin
            capture   = 1'b1;
            row_cnt_d = row_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      load_mode_q <= '0;
      buf_q       <= '0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      if (load_start) begin
        load_mode_q <= mode;
      end
      for (int unsigned i = 0; i < N - 1; i++) begin
        if (capture && row_cnt_q == CNT_W'(i)) begin
          buf_q[i*ROW_W +: ROW_W] <= data_in;
        end
      end
      // A new error wins over a simultaneous clear.
      err_ovf <= (err_ovf & ~err_clr) | (|ovf_v);
      err_unf <= (err_unf & ~err_clr) | (|unf_v);
    end
  end

endmodule

// File: tb/tb_matrix_stack_ctrl.sv
// Self-checking bench for matrix_stack_ctrl against a queue/array stack model.
module tb_matrix_stack_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned EW    = 32;
  localparam int unsigned D     = 8;
  localparam int unsigned NS    = 2;
  localparam int unsigned ROW_W = N * EW;
  localparam int unsigned MAT_W = N * ROW_W;

  logic             clk = 1'b0;
  logic             reset_n, stall, cmd_valid, data_valid, err_clr;
  logic             mode;
  logic [2:0]       cmd_op;
  logic [ROW_W-1:0] data_in;
  logic [MAT_W-1:0] write_in, peek_out;
  logic [2:0]       depth;
  logic             cmd_ready, data_ready, busy, err_ovf, err_unf;

  always #5 clk = ~clk;

  matrix_stack_ctrl dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .mode(mode),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .write_in(write_in), .peek_out(peek_out), .depth(depth), .busy(busy),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays of matrices, integer stack pointers, a row queue.
  logic [MAT_W-1:0] m_stk [NS][D];
  int               m_sp  [NS];
  bit               m_loading, m_ovf, m_unf;
  int               m_lmode;
  logic [ROW_W-1:0] m_rows [$];

  function automatic logic [MAT_W-1:0] ident();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[r*ROW_W + (N-1-r)*EW +: EW] = 32'h3F800000;
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] fill(input logic [EW-1:0] v);
    logic [MAT_W-1:0] m;
    for (int i = 0; i < N * N; i++) m[i*EW +: EW] = v;
    return m;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_sp[s] = 0;
      for (int i = 0; i < D; i++) m_stk[s][i] = ident();
    end
`ifdef MATRIX_ORTHO_RESET_EN
    m_stk[1][0] = {128'h00000000_00000000_00000000_3F800000,
                   128'h00000000_00000000_BF800000_00000000,
                   128'h00000000_3B888889_00000000_BF800000,
                   128'h3B4CCCCD_00000000_00000000_BF800000};
`endif
    m_loading = 0; m_ovf = 0; m_unf = 0; m_lmode = 0;
    m_rows.delete();
  endtask

  task automatic model_step();
    bit ovf_ev, unf_ev;
    int s;
    logic [MAT_W-1:0] mat;
    ovf_ev = 0; unf_ev = 0;
    s = int'(mode);
    if (!stall) begin
      if (!m_loading) begin
        if (cmd_valid) begin
          case (cmd_op)
            3'd1: if (m_sp[s] == D - 1) ovf_ev = 1;
                  else begin m_stk[s][m_sp[s]+1] = m_stk[s][m_sp[s]]; m_sp[s]++; end
            3'd2: if (m_sp[s] == 0) unf_ev = 1; else m_sp[s]--;
            3'd3: begin m_loading = 1; m_lmode = s; m_rows.delete(); end
            3'd4: m_stk[s][m_sp[s]] = ident();
            3'd5: m_stk[s][m_sp[s]] = write_in;
            default: ;
          endcase
        end
      end else if (data_valid) begin
        m_rows.push_back(data_in);
        if (m_rows.size() == N) begin
          for (int r = 0; r < N; r++) mat[r*ROW_W +: ROW_W] = m_rows[r];
          m_stk[m_lmode][m_sp[m_lmode]] = mat;
          m_loading = 0;
        end
      end
    end
    m_ovf = (m_ovf && !err_clr) || ovf_ev;
    m_unf = (m_unf && !err_clr) || unf_ev;
  endtask

  task automatic check_outputs();
    check("peek",    peek_out, m_stk[int'(mode)][m_sp[int'(mode)]]);
    check("depth",   MAT_W'(depth), MAT_W'(m_sp[int'(mode)]));
    check("busy",    MAT_W'(busy), MAT_W'(m_loading));
    check("err_ovf", MAT_W'(err_ovf), MAT_W'(m_ovf));
    check("err_unf", MAT_W'(err_unf), MAT_W'(m_unf));
  endtask

  // Called just after an active edge with inputs set; advances one cycle.
  task automatic tick();
    #1;
    check("cmd_ready",  MAT_W'(cmd_ready),  MAT_W'(!m_loading && !stall));
    check("data_ready", MAT_W'(data_ready), MAT_W'(m_loading && !stall));
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic issue(input logic [2:0] op, input logic md);
    cmd_valid = 1'b1; cmd_op = op; mode = md;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] r);
    data_valid = 1'b1; data_in = r;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check("rst_busy", MAT_W'(busy), MAT_W'(0));
    check("rst_peek", peek_out, m_stk[int'(mode)][0]);
    #10;
    reset_n = 1'b1;
  endtask

  logic [ROW_W-1:0] rw [4];
  logic [MAT_W-1:0] mat_m;

  initial begin
    reset_n = 1'b0; stall = 0; cmd_valid = 0; data_valid = 0; err_clr = 0;
    mode = 0; cmd_op = 0; data_in = '0; write_in = '0;
    model_reset();
    #22 reset_n = 1'b1;

    // Reset state
    check("reset_peek",  peek_out, ident());
    check("reset_depth", MAT_W'(depth), MAT_W'(0));
    check("reset_busy",  MAT_W'(busy), MAT_W'(0));
    check("reset_ovf",   MAT_W'(err_ovf), MAT_W'(0));
    check("reset_unf",   MAT_W'(err_unf), MAT_W'(0));
    check("reset_cmd_ready", MAT_W'(cmd_ready), MAT_W'(1));
    check("reset_data_ready", MAT_W'(data_ready), MAT_W'(0));

    // WRITE / PUSH / LOAD_ID / POP
    mat_m = fill(32'h40000000);
    write_in = mat_m;
    issue(3'd5, 1'b0);
    issue(3'd1, 1'b0);
    check("push_depth", MAT_W'(depth), MAT_W'(1));
    issue(3'd4, 1'b0);
    check("load_id_peek", peek_out, ident());
    issue(3'd2, 1'b0);
    check("pop_depth", MAT_W'(depth), MAT_W'(0));
    check("pop_peek", peek_out, mat_m);

    // Overflow at full depth, then clear
    for (int i = 0; i < 7; i++) issue(3'd1, 1'b0);
    check("full_depth", MAT_W'(depth), MAT_W'(7));
    issue(3'd1, 1'b0);
    check("ovf_depth", MAT_W'(depth), MAT_W'(7));
    check("ovf_flag", MAT_W'(err_ovf), MAT_W'(1));
    check("ovf_peek", peek_out, mat_m);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf_clr", MAT_W'(err_ovf), MAT_W'(0));

    // Underflow from a fresh reset
    do_reset();
    issue(3'd2, 1'b0);
    check("unf_flag", MAT_W'(err_unf), MAT_W'(1));
    check("unf_depth", MAT_W'(depth), MAT_W'(0));
    check("unf_peek", peek_out, ident());

    // LOAD into stack 1 with a stall and a mode change mid-load
    for (int r = 0; r < 4; r++) rw[r] = {$urandom, $urandom, $urandom, $urandom};
    issue(3'd3, 1'b1);
    send_row(rw[0]);
    send_row(rw[1]);
    stall = 1'b1; data_valid = 1'b1; data_in = rw[2]; mode = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_data_ready", MAT_W'(data_ready), MAT_W'(0));
    stall = 1'b0;
    send_row(rw[2]);
    mode = 1'b1;
    #1;
    check("no_partial", peek_out, m_stk[1][0]);
    send_row(rw[3]);
    check("load_done", peek_out, {rw[3], rw[2], rw[1], rw[0]});
    mode = 1'b0;
    tick();
    check("s0_untouched", peek_out, ident());

    // Reset in the middle of a LOAD
    issue(3'd3, 1'b1);
    send_row(rw[0]);
    send_row(rw[1]);
    send_row(rw[2]);
    do_reset();
    issue(3'd1, 1'b0);
    check("post_reset_push", MAT_W'(depth), MAT_W'(1));

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      int sel;
      stall      = ($urandom_range(0, 4) == 0);
      mode       = 1'($urandom_range(0, 1));
      cmd_valid  = 1'($urandom_range(0, 1));
      sel        = $urandom_range(0, 9);
      cmd_op     = (sel <= 2) ? 3'd1 : (sel <= 4) ? 3'd2 : (sel == 5) ? 3'd3 :
                   (sel == 6) ? 3'd4 : (sel == 7) ? 3'd5 : (sel == 8) ? 3'd0 :
                   3'(6 + $urandom_range(0, 1));
      data_valid = 1'($urandom_range(0, 1));
      data_in    = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < N * N; i++) write_in[i*EW +: EW] = $urandom;
      err_clr    = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
